// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared FSM state type and slice width for add_seq
package add_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add4_slice.sv
// rtl/add4_slice.sv - combinational 4-bit adder slice with carry in/out
module add4_slice
  import add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/add_seq.sv
// rtl/add_seq.sv - two-requester sequential adder iterating one 4-bit slice LSB first
// Optional subtract ports and datapath enabled by macro ADD_SEQ_SUB_EN.
module add_seq
  import add_seq_pkg::*;
#(
  parameter  int NSLICE = 4,
  localparam int W      = SLICE_W * NSLICE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
`ifdef ADD_SEQ_SUB_EN
  input  logic         req0_sub,
  input  logic         req1_sub,
`endif
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id
);

  localparam int             IW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0]  LAST = IW'(NSLICE - 1);

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          sub_q;
  logic          carry_q;
  logic          id_q;
  logic          last_grant;
  logic [IW-1:0] idx;

  logic          grant_id;
  logic          accept;
  logic          sub_sel;
  logic [W-1:0]  a_sel;
  logic [W-1:0]  b_sel;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_sum;
  logic               sl_cout;

  // On a tie the requester not granted last time wins; last_grant resets to 1.
  always_comb begin
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else                          grant_id = req1_valid;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant_id;
  assign accept     = req0_ready || req1_ready;

  assign a_sel = grant_id ? req1_a : req0_a;
  assign b_sel = grant_id ? req1_b : req0_b;

`ifdef ADD_SEQ_SUB_EN
  assign sub_sel = grant_id ? req1_sub : req0_sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Subtraction is a + ~b + 1: b is inverted here and the +1 comes from the carry preload.
  assign sl_a = a_q[idx*SLICE_W +: SLICE_W];
  assign sl_b = b_q[idx*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_q}};

  add4_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= 1'b0;
      carry_q    <= 1'b0;
      idx        <= '0;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      id_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q        <= a_sel;
            b_q        <= b_sel;
            sub_q      <= sub_sel;
            id_q       <= grant_id;
            last_grant <= grant_id;
            carry_q    <= sub_sel;
            idx        <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          rsp_sum[idx*SLICE_W +: SLICE_W] <= sl_sum;
          carry_q <= sl_cout;
          if (idx == LAST) begin
            rsp_valid <= 1'b1;
            rsp_cout  <= sl_cout;
            rsp_id    <= id_q;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Leaving DONE lands in IDLE, so no accept can coincide with the handoff.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq.sv
// tb/tb_add_seq.sv - self-checking bench for add_seq with randomized reference-model checks
`timescale 1ns/1ps
module tb_add_seq;

  localparam int NSLICE = 4;
  localparam int W      = 4 * NSLICE;
  localparam int LAT    = NSLICE + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
`ifdef ADD_SEQ_SUB_EN
  logic         req0_sub, req1_sub;
`endif
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout, rsp_id;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  add_seq #(.NSLICE(NSLICE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
`ifdef ADD_SEQ_SUB_EN
    .req0_sub   (req0_sub),
    .req1_sub   (req1_sub),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Result from plain arithmetic: {cout, sum}; for subtraction cout means a >= b (no borrow).
  function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
    logic [W-1:0] d;
    if (sub) begin
      d = a - b;
      return {(a >= b), d};
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub);
    if (id) begin
      req1_a = a; req1_b = b;
`ifdef ADD_SEQ_SUB_EN
      req1_sub = sub;
`endif
    end else begin
      req0_a = a; req0_b = b;
`ifdef ADD_SEQ_SUB_EN
      req0_sub = sub;
`endif
    end
  endtask

  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, output logic [W-1:0] s, output logic c,
                       output logic rid, output int lat, output bit to);
    int n;
    int t_acc;
    to = 0; lat = -1; s = '0; c = 1'b0; rid = 1'b0;
    set_req(id, a, b, sub);
    if (id) req1_valid = 1'b1; else req0_valid = 1'b1;
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      to = 1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    t_acc = cyc;
    tick();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    if (n >= 50) begin to = 1; return; end
    lat = cyc - t_acc;
    s = rsp_sum; c = rsp_cout; rid = rsp_id;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got v=%b s=%h c=%b id=%b exp 0 0000 0 0",
               rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    rst = 1'b0;
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_tie got r0=%b r1=%b exp 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [W-1:0] s; logic c, rid; int lat; bit to;
    do_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, s, c, rid, lat, to);
    vectors++;
    if (to || s !== 16'h2233 || c !== 1'b0 || rid !== 1'b0 || lat != LAT) begin
      miscompares++;
      $display("FAIL directed_add0 got s=%h c=%b id=%b lat=%0d to=%0d exp 2233 0 0 %0d 0",
               s, c, rid, lat, to, LAT);
    end
    do_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, s, c, rid, lat, to);
    vectors++;
    if (to || s !== 16'h0000 || c !== 1'b1 || rid !== 1'b1 || lat != LAT) begin
      miscompares++;
      $display("FAIL directed_add1_wrap got s=%h c=%b id=%b lat=%0d to=%0d exp 0000 1 1 %0d 0",
               s, c, rid, lat, to, LAT);
    end
  endtask

  task automatic test_arbitration();
    logic [W-1:0] a0, b0, a1, b1;
    logic [W:0]   e0, e1;
    logic         got_id [2];
    logic [W:0]   got_res [2];
    int got, n;
    logic acc0, acc1;
    do_reset();
    for (int round = 0; round < 2; round++) begin
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      e0 = ref_result(a0, b0, 1'b0);
      e1 = ref_result(a1, b1, 1'b0);
      set_req(1'b0, a0, b0, 1'b0);
      set_req(1'b1, a1, b1, 1'b0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      got = 0; n = 0;
      while (got < 2 && n < 60) begin
        vectors++;
        if (req0_ready && req1_ready) begin
          miscompares++;
          $display("FAIL arb_both_ready got r0=%b r1=%b exp not both", req0_ready, req1_ready);
        end
        acc0 = req0_ready; acc1 = req1_ready;
        if (rsp_valid) begin
          got_id[got] = rsp_id;
          got_res[got] = {rsp_cout, rsp_sum};
          got++;
        end
        tick();
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
        n++;
      end
      vectors++;
      if (got != 2) begin
        miscompares++;
        $display("FAIL arb_resp_count round %0d got %0d exp 2", round, got);
        req0_valid = 1'b0; req1_valid = 1'b0;
      end else if (got_id[0] !== 1'b0 || got_id[1] !== 1'b1 ||
                   got_res[0] !== e0 || got_res[1] !== e1) begin
        miscompares++;
        $display("FAIL arb_order round %0d got %b:%h %b:%h exp 0:%h 1:%h",
                 round, got_id[0], got_res[0], got_id[1], got_res[1], e0, e1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, a1, b1;
    logic [W:0]   e, e1;
    int n;
    a = W'($urandom); b = W'($urandom); e = ref_result(a, b, 1'b0);
    a1 = W'($urandom); b1 = W'($urandom); e1 = ref_result(a1, b1, 1'b0);
    rsp_ready = 1'b0;
    set_req(1'b0, a, b, 1'b0);
    req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin tick(); n++; end
    tick();
    req0_valid = 1'b0;
    set_req(1'b1, a1, b1, 1'b0);
    req1_valid = 1'b1;
    #1;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || {rsp_cout, rsp_sum} !== e || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold cyc %0d got v=%b r=%h id=%b r0=%b r1=%b exp 1 %h 0 0 0",
                 i, rsp_valid, {rsp_cout, rsp_sum}, rsp_id, req0_ready, req1_ready, e);
      end
      tick();
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_exit_cycle got r0=%b r1=%b v=%b exp 0 0 1", req0_ready, req1_ready, rsp_valid);
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release got v=%b r0=%b r1=%b exp 0 0 1", rsp_valid, req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || {rsp_cout, rsp_sum} !== e1) begin
      miscompares++;
      $display("FAIL bp_waiter got v=%b id=%b r=%h exp 1 1 %h", rsp_valid, rsp_id,
               {rsp_cout, rsp_sum}, e1);
    end
    tick();
  endtask

`ifdef ADD_SEQ_SUB_EN
  task automatic test_sub();
    logic [W-1:0] s; logic c, rid; int lat; bit to;
    do_op(1'b0, 16'h0005, 16'h0007, 1'b1, s, c, rid, lat, to);
    vectors++;
    if (to || s !== 16'hFFFE || c !== 1'b0 || rid !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_borrow got s=%h c=%b id=%b exp fffe 0 0", s, c, rid);
    end
    do_op(1'b1, 16'h0007, 16'h0005, 1'b1, s, c, rid, lat, to);
    vectors++;
    if (to || s !== 16'h0002 || c !== 1'b1 || rid !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_noborrow got s=%h c=%b id=%b exp 0002 1 1", s, c, rid);
    end
  endtask
`endif

  task automatic test_reset_midrun();
    logic [W-1:0] s; logic c, rid; int lat; bit to;
    logic [W-1:0] a, b;
    logic [W:0]   e;
    bit seen;
    int n;
    set_req(1'b0, 16'hABCD, 16'h1111, 1'b0);
    req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin tick(); n++; end
    tick();
    req0_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset_outputs got v=%b s=%h c=%b id=%b exp 0 0000 0 0",
               rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) seen = 1;
      tick();
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL midrun_no_response got rsp_valid seen=1 exp 0");
    end
    a = W'($urandom); b = W'($urandom); e = ref_result(a, b, 1'b0);
    do_op(1'b1, a, b, 1'b0, s, c, rid, lat, to);
    vectors++;
    if (to || {c, s} !== e || rid !== 1'b1 || lat != LAT) begin
      miscompares++;
      $display("FAIL midrun_next_op got r=%h id=%b lat=%0d exp %h 1 %0d", {c, s}, rid, lat, e, LAT);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] s, a, b; logic c, rid, id, sub; int lat; bit to;
    logic [W:0] e;
    for (int i = 0; i < 40; i++) begin
      id = 1'($urandom);
      a  = W'($urandom);
      b  = (i % 8 == 0) ? ~a : W'($urandom);
`ifdef ADD_SEQ_SUB_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      e = ref_result(a, b, sub);
      do_op(id, a, b, sub, s, c, rid, lat, to);
      vectors++;
      if (to || {c, s} !== e || rid !== id || lat != LAT) begin
        miscompares++;
        $display("FAIL random_op %0d a=%h b=%h sub=%b got r=%h id=%b lat=%0d exp %h %b %0d",
                 i, a, b, sub, {c, s}, rid, lat, e, id, LAT);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
`ifdef ADD_SEQ_SUB_EN
    req0_sub = 1'b0; req1_sub = 1'b0;
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_arbitration();
    test_backpressure();
`ifdef ADD_SEQ_SUB_EN
    test_sub();
`endif
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
